effect_sequencer: RTL

//  Parametrised opcode sequencer for the Halloween decoration: latches an NCH-entry program of
//  4-bit effect opcodes and steps through it, holding each step for DWELL clocks. Drives decoded
//  one-hot effects, sticky colour, sound pulses and movement enables to the effect drivers.

---
 rtl/halloween_pkg.sv | 50 +++++
 rtl/effect_decode.sv | 27 ++
 rtl/effect_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/halloween_pkg.sv
// Shared opcode, class, colour and state definitions for the decoration sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package halloween_pkg;

  // Effect opcodes. Codes 0010, 0011, 0111, 1011 and 1111 are undefined.
  localparam logic [3:0] OP_ON        = 4'b0000;
  localparam logic [3:0] OP_RESET     = 4'b0001;
  localparam logic [3:0] OP_GREEN     = 4'b0100;
  localparam logic [3:0] OP_PURPLE    = 4'b0101;
  localparam logic [3:0] OP_ORANGE    = 4'b0110;
  localparam logic [3:0] OP_SCREAMING = 4'b1000;
  localparam logic [3:0] OP_CACKLING  = 4'b1001;
  localparam logic [3:0] OP_BOO       = 4'b1010;
  localparam logic [3:0] OP_WAVEHANDS = 4'b1100;
  localparam logic [3:0] OP_MOVEJAW   = 4'b1101;
  localparam logic [3:0] OP_FOG       = 4'b1110;

  // The opcode class is simply the top two opcode bits.
  typedef enum logic [1:0] {
    CLS_SYS   = 2'b00,
    CLS_COLOR = 2'b01,
    CLS_SOUND = 2'b10,
    CLS_MOVE  = 2'b11
  } op_class_e;

  typedef enum logic [1:0] {
    COL_NONE   = 2'b00,
    COL_GREEN  = 2'b01,
    COL_PURPLE = 2'b10,
    COL_ORANGE = 2'b11
  } color_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    logic ok;
    case (op)
      OP_ON, OP_RESET, OP_GREEN, OP_PURPLE, OP_ORANGE,
      OP_SCREAMING, OP_CACKLING, OP_BOO,
      OP_WAVEHANDS, OP_MOVEJAW, OP_FOG: ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/effect_decode.sv
// Opcode decoder: one-hot, class, colour code and illegal flag for one 4-bit opcode.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: op (in, 4) opcode; onehot (out, 16) 1<<op; op_class (out) top-bit class;
//        color_code (out) colour for legal colour ops else NONE; illegal (out) undefined opcode.
module effect_decode
  import halloween_pkg::*;
(
  input  logic [3:0]  op,
  output logic [15:0] onehot,
  output op_class_e   op_class,
  output color_e      color_code,
  output logic        illegal
);

  always_comb begin
    onehot     = 16'h1 << op;
    op_class   = op_class_e'(op[3:2]);
    illegal    = !op_is_legal(op);
    color_code = COL_NONE;
    // GREEN/PURPLE/ORANGE are 0100/0101/0110, so the colour is low bits + 1.
    if (op_class == CLS_COLOR && !illegal) begin
      color_code = color_e'(op[1:0] + 2'd1);
    end
  end

endmodule

// File: rtl/effect_sequencer.sv
// Steps through a latched NCH-entry opcode program, DWELL clocks per step, driving effects.
// Latency: outputs are combinational from registered state (cur_op valid the cycle after start).
// Backpressure: none; start/stop are levels sampled every clock, start ignored while busy.
// Ports: clk, rst_n (async active-low); start, stop, prog[NCH*4] in;
//        busy, step_idx, cur_op, dec_out, color, sound_pulse, move_active, wrap, illegal out.
module effect_sequencer
  import halloween_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int DWELL = 1,
  localparam int SW    = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic [NCH*4-1:0] prog,
  output logic            busy,
  output logic [SW-1:0]   step_idx,
  output logic [3:0]      cur_op,
  output logic [15:0]     dec_out,
  output color_e          color,
  output logic            sound_pulse,
  output logic            move_active,
  output logic            wrap,
  output logic            illegal
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_e           state_q, state_d;
  logic [NCH*4-1:0] prog_q,  prog_d;
  logic [SW-1:0]    step_q,  step_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  color_e           color_q, color_d;

  logic             run;
  logic             first_cyc;
  logic             last_cyc;
  logic [15:0]      op_onehot;
  op_class_e        op_class;
  color_e           op_color;
  logic             op_illegal;

  assign run       = (state_q == ST_RUN);
  assign first_cyc = (cnt_q == '0);
  assign last_cyc  = (cnt_q == CW'(DWELL - 1));
  // Gated so IDLE shows 0000 rather than the stale latched entry.
  assign cur_op    = run ? prog_q[{step_q, 2'b00} +: 4] : 4'h0;

  effect_decode u_decode (
    .op         (cur_op),
    .onehot     (op_onehot),
    .op_class   (op_class),
    .color_code (op_color),
    .illegal    (op_illegal)
  );

  // Pulses are suppressed in a stop cycle; undefined opcodes behave as no-ops.
  always_comb begin
    busy        = run;
    step_idx    = step_q;
    color       = color_q;
    dec_out     = run ? op_onehot : 16'h0;
    sound_pulse = run && first_cyc && !stop && (op_class == CLS_SOUND) && !op_illegal;
    illegal     = run && first_cyc && !stop && op_illegal;
    move_active = run && (op_class == CLS_MOVE) && !op_illegal;
    wrap        = run && last_cyc && !stop && (cur_op != OP_RESET) &&
                  (step_q == SW'(NCH - 1));
  end

  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    case (state_q)
      ST_IDLE: begin
        // An all-zero program is treated as "nothing loaded".
        if (start && (prog != '0)) begin
          state_d = ST_RUN;
          prog_d  = prog;
          step_d  = '0;
          cnt_d   = '0;
          color_d = COL_NONE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          // Stop takes priority over any step end in the same cycle.
          state_d = ST_IDLE;
          step_d  = '0;
          cnt_d   = '0;
          color_d = COL_NONE;
        end else begin
          if (first_cyc && (op_color != COL_NONE)) begin
            color_d = op_color;
          end
          if (last_cyc) begin
            cnt_d = '0;
            if (cur_op == OP_RESET) begin
              step_d  = '0;
              color_d = COL_NONE;
            end else if (step_q == SW'(NCH - 1)) begin
              step_d = '0;
            end else begin
              step_d = step_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      prog_q  <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      color_q <= COL_NONE;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
    end
  end

endmodule
